// File: rtl/math_cabs_seq.sv
// math_cabs_seq: handshaked exact complex magnitude floor(sqrt(I^2+Q^2)) or power I^2+Q^2.
// One sample in flight; bit-serial restoring square root, two radicand bits per cycle.
module math_cabs_seq #(
  parameter int DIN_WIDTH = 16,
  parameter int TAG_WIDTH = 4,
  localparam int DOUT_WIDTH = 2*DIN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIN_WIDTH-1:0] in_i,
  input  logic signed [DIN_WIDTH-1:0] in_q,
  input  logic                        in_mode,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DOUT_WIDTH-1:0]       out_data,
  output logic                        out_mode,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        busy
);
  localparam int CW = $clog2(DIN_WIDTH);
  localparam logic [1:0] IDLE = 2'd0, SQ = 2'd1, ROOT = 2'd2, DONE = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [DIN_WIDTH-1:0]  a_q, a_d, b_q, b_d, r_q, r_d, abs_i, abs_q;
  logic [DIN_WIDTH+1:0]  rem_q, rem_d, rem_sh, trial;
  logic [DOUT_WIDTH-1:0] s_q, s_d, data_q, data_d, sq;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d, fit;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  // Negating the most negative input wraps back to 2^(W-1), which is correct as unsigned.
  assign abs_i  = in_i[DIN_WIDTH-1] ? DIN_WIDTH'(-in_i) : DIN_WIDTH'(in_i);
  assign abs_q  = in_q[DIN_WIDTH-1] ? DIN_WIDTH'(-in_q) : DIN_WIDTH'(in_q);
  assign sq     = DOUT_WIDTH'(a_q) * DOUT_WIDTH'(a_q) + DOUT_WIDTH'(b_q) * DOUT_WIDTH'(b_q);
  // The radicand is shifted left each iteration so the next pair is always at the top.
  assign rem_sh = {rem_q[DIN_WIDTH-1:0], s_q[DOUT_WIDTH-1 -: 2]};
  assign trial  = {r_q, 2'b01};
  assign fit    = rem_sh >= trial;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    rem_d   = rem_q;
    s_d     = s_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = abs_i;
      b_d     = abs_q;
      mode_d  = in_mode;
      tag_d   = in_tag;
      state_d = SQ;
    end else if (state_q == SQ) begin
      s_d     = sq;
      r_d     = '0;
      rem_d   = '0;
      cnt_d   = CW'(DIN_WIDTH-1);
      data_d  = mode_q ? sq : data_q;
      state_d = mode_q ? DONE : ROOT;
    end else if (state_q == ROOT) begin
      rem_d   = fit ? rem_sh - trial : rem_sh;
      r_d     = {r_q[DIN_WIDTH-2:0], fit};
      s_d     = s_q << 2;
      cnt_d   = cnt_q - 1'b1;
      data_d  = (cnt_q == '0) ? DOUT_WIDTH'({r_q[DIN_WIDTH-2:0], fit}) : data_q;
      state_d = (cnt_q == '0) ? DONE : ROOT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      rem_q   <= '0;
      s_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      s_q     <= s_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end
  assign in_ready  = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign out_tag   = tag_q;
endmodule
